// File: rtl/time_keeper.sv
// ---------------------------------------------------------------------------
// time_keeper
//   24-hour time-of-day counter (hour/min/sec, binary) with a button-driven
//   set mode. In counting mode a prescaler divides clk down to one-second
//   ticks. With mode=1, an ENTER press opens setting. In setting mode
//   up/down edit the selected field and left/right pick the field
//   (hour/minute). ESC or ENTER returns to counting.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   mode                       1 = buttons belong to this block
//   up, down, left, right,
//   enter, esc                 debounced button levels
//   hour, min, sec [6:0]       registered time of day
//   tick                       one-cycle pulse when sec takes a new value
//   norm                       1 = counting, 0 = setting
//   sel                        edited field: 0 = hour, 1 = minute
// ---------------------------------------------------------------------------
module time_keeper #(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mode,
    input  logic       up,
    input  logic       down,
    input  logic       left,
    input  logic       right,
    input  logic       enter,
    input  logic       esc,
    output logic [6:0] hour,
    output logic [6:0] min,
    output logic [6:0] sec,
    output logic       tick,
    output logic       norm,
    output logic       sel
);

    localparam int PW = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_MAX  = PW'(CLK_HZ - 1);
    localparam logic [PW-1:0] PRESC_ZERO = {PW{1'b0}};
    localparam logic [PW-1:0] PRESC_ONE  = PW'(1);

    typedef enum logic [0:0] {
        ST_NORM = 1'b0,
        ST_SET  = 1'b1
    } state_t;

    state_t        state_r, state_s;
    logic [PW-1:0] presc_r, presc_s;
    logic [6:0]    hour_r, hour_s;
    logic [6:0]    min_r, min_s;
    logic [6:0]    sec_r, sec_s;
    logic          tick_r, tick_s;
    logic          norm_r, norm_s;
    logic          sel_r, sel_s;
    logic [5:0]    btn_q_r;
    logic [5:0]    btn_s;
    logic [5:0]    press_s;
    logic          esc_p_s, enter_p_s, lr_p_s, up_p_s, down_p_s;

    // Wrapping increment of a field whose largest value is top.
    function automatic logic [6:0] wrap_inc(input logic [6:0] v, input logic [6:0] top);
        return (v == top) ? 7'd0 : v + 7'd1;
    endfunction

    // Wrapping decrement of a field whose largest value is top.
    function automatic logic [6:0] wrap_dec(input logic [6:0] v, input logic [6:0] top);
        return (v == 7'd0) ? top : v - 7'd1;
    endfunction

    assign btn_s = {esc, enter, left, right, up, down};

    // History is tracked in every mode so a button held while another
    // block owned the keys cannot produce an edge when mode returns.
    assign press_s   = btn_s & ~btn_q_r & {6{mode}};
    assign esc_p_s   = press_s[5];
    assign enter_p_s = press_s[4];
    assign lr_p_s    = press_s[3] | press_s[2];
    assign up_p_s    = press_s[1];
    assign down_p_s  = press_s[0];

    // Button history flops for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_q_r <= 6'b000000;
        end else begin
            btn_q_r <= btn_s;
        end
    end

    // Next-state logic: counting, set-mode entry/exit and field edits.
    always_comb begin
        state_s = state_r;
        presc_s = presc_r;
        hour_s  = hour_r;
        min_s   = min_r;
        sec_s   = sec_r;
        sel_s   = sel_r;
        tick_s  = 1'b0;
        case (state_r)
            ST_NORM: begin
                if (enter_p_s) begin
                    state_s = ST_SET;
                    sel_s   = 1'b0;
                    sec_s   = 7'd0;
                    presc_s = PRESC_ZERO;
                end else if (presc_r == PRESC_MAX) begin
                    presc_s = PRESC_ZERO;
                    tick_s  = 1'b1;
                    sec_s   = wrap_inc(sec_r, 7'd59);
                    if (sec_r == 7'd59) begin
                        min_s = wrap_inc(min_r, 7'd59);
                        if (min_r == 7'd59) begin
                            hour_s = wrap_inc(hour_r, 7'd23);
                        end else begin
                            hour_s = hour_r;
                        end
                    end else begin
                        min_s = min_r;
                    end
                end else begin
                    presc_s = presc_r + PRESC_ONE;
                end
            end
            ST_SET: begin
                presc_s = PRESC_ZERO;
                if (esc_p_s || enter_p_s) begin
                    state_s = ST_NORM;
                    sel_s   = 1'b0;
                end else if (lr_p_s) begin
                    sel_s = ~sel_r;
                end else if (up_p_s && !down_p_s) begin
                    if (sel_r) begin
                        min_s = wrap_inc(min_r, 7'd59);
                    end else begin
                        hour_s = wrap_inc(hour_r, 7'd23);
                    end
                end else if (down_p_s && !up_p_s) begin
                    if (sel_r) begin
                        min_s = wrap_dec(min_r, 7'd59);
                    end else begin
                        hour_s = wrap_dec(hour_r, 7'd23);
                    end
                end else begin
                    sel_s = sel_r;
                end
            end
            default: begin
                state_s = ST_NORM;
                presc_s = PRESC_ZERO;
                sel_s   = 1'b0;
            end
        endcase
        norm_s = (state_s == ST_NORM);
    end

    // State, prescaler and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_NORM;
            presc_r <= PRESC_ZERO;
            hour_r  <= 7'd0;
            min_r   <= 7'd0;
            sec_r   <= 7'd0;
            tick_r  <= 1'b0;
            norm_r  <= 1'b1;
            sel_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            presc_r <= presc_s;
            hour_r  <= hour_s;
            min_r   <= min_s;
            sec_r   <= sec_s;
            tick_r  <= tick_s;
            norm_r  <= norm_s;
            sel_r   <= sel_s;
        end
    end

    assign hour = hour_r;
    assign min  = min_r;
    assign sec  = sec_r;
    assign tick = tick_r;
    assign norm = norm_r;
    assign sel  = sel_r;

endmodule

// File: tb/tb_time_keeper.sv
// ---------------------------------------------------------------------------
// tb_time_keeper
//   Self-checking bench for time_keeper with CLK_HZ=4. The reference model
//   keeps the time as a count of seconds since midnight plus a count of clk
//   cycles since the last prescaler restart. Expected outputs are derived
//   from those with division/modulo.
// ---------------------------------------------------------------------------
module tb_time_keeper;

    localparam int CLK_HZ = 4;

    logic       clk, rst_n, mode;
    logic       up, down, left, right, enter, esc;
    logic [6:0] hour, min, sec;
    logic       tick, norm, sel;

    int total = 0;
    int bad   = 0;

    // reference model state
    int       m_secs;
    int       m_cnt;
    bit       m_set;
    bit       m_sel;
    bit       m_tick;
    bit [5:0] m_prev;

    time_keeper #(.CLK_HZ(CLK_HZ)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode),
        .up(up), .down(down), .left(left), .right(right),
        .enter(enter), .esc(esc),
        .hour(hour), .min(min), .sec(sec),
        .tick(tick), .norm(norm), .sel(sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] exp_vec();
        int h, mi, s;
        h  = m_secs / 3600;
        mi = (m_secs / 60) % 60;
        s  = m_secs % 60;
        return {7'(h), 7'(mi), 7'(s), m_tick, ~m_set, m_sel};
    endfunction

    function automatic logic [23:0] obs_vec();
        return {hour, min, sec, tick, norm, sel};
    endfunction

    function automatic int m_hour();
        return m_secs / 3600;
    endfunction

    task automatic model_reset();
        m_secs = 0; m_cnt = 0; m_set = 1'b0; m_sel = 1'b0;
        m_tick = 1'b0; m_prev = 6'b000000;
    endtask

    // One clk edge of the model, using the input levels present at the edge.
    task automatic model_step();
        bit [5:0] b, p;
        int h, mi, s, d;
        b = {esc, enter, left, right, up, down};
        p = b & ~m_prev & {6{mode}};
        m_prev = b;
        m_tick = 1'b0;
        h  = m_secs / 3600;
        mi = (m_secs / 60) % 60;
        s  = m_secs % 60;
        if (!m_set) begin
            if (p[4]) begin
                m_set = 1'b1; m_sel = 1'b0; m_secs = m_secs - s; m_cnt = 0;
            end else begin
                m_cnt++;
                if (m_cnt == CLK_HZ) begin
                    m_cnt  = 0;
                    m_secs = (m_secs + 1) % 86400;
                    m_tick = 1'b1;
                end
            end
        end else begin
            m_cnt = 0;
            if (p[5] || p[4]) begin
                m_set = 1'b0; m_sel = 1'b0;
            end else if (p[3] || p[2]) begin
                m_sel = ~m_sel;
            end else if (p[1] != p[0]) begin
                d = p[1] ? 1 : -1;
                if (!m_sel) h = (h + 24 + d) % 24;
                else        mi = (mi + 60 + d) % 60;
                m_secs = h * 3600 + mi * 60 + s;
            end
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic release_buttons();
        up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0;
        enter = 1'b0; esc = 1'b0;
    endtask

    // idx: 0=down 1=up 2=right 3=left 4=enter 5=esc
    task automatic pulse(input int idx);
        case (idx)
            0: down  = 1'b1;
            1: up    = 1'b1;
            2: right = 1'b1;
            3: left  = 1'b1;
            4: enter = 1'b1;
            5: esc   = 1'b1;
            default: ;
        endcase
        step();
        release_buttons();
        step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        release_buttons();
        mode = 1'b1;
        model_reset();
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        release_buttons();
        mode = 1'b0;
        model_reset();
        #1;
        total++;
        if (obs_vec() !== 24'h000002) begin
            bad++; $display("FAIL reset_state got=%h exp=%h", obs_vec(), 24'h000002);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++; $display("FAIL reset_run got=%h exp=%h", obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_count();
        do_reset();
        for (int i = 1; i <= 240; i++) begin
            step();
            total++;
            if (obs_vec() !== exp_vec() || tick !== ((i % 4) == 0)) begin
                bad++; $display("FAIL count cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
            end
        end
        total++;
        if ({hour, min, sec, tick} !== {7'd0, 7'd1, 7'd0, 1'b1}) begin
            bad++; $display("FAIL count_240 got=%0d:%0d:%0d t=%b exp=0:1:0 t=1", hour, min, sec, tick);
        end
    endtask

    task automatic test_rollover();
        int seq [5] = '{4, 0, 2, 0, 5};
        do_reset();
        foreach (seq[k]) begin
            pulse(seq[k]);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++; $display("FAIL preload k=%0d got=%h exp=%h", k, obs_vec(), exp_vec());
            end
        end
        for (int i = 0; i < 4 * 59 - 1; i++) begin
            step();
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++; $display("FAIL roll_wait got=%h exp=%h", obs_vec(), exp_vec());
            end
        end
        total++;
        if ({hour, min, sec, norm} !== {7'd23, 7'd59, 7'd59, 1'b1}) begin
            bad++; $display("FAIL roll_pre got=%0d:%0d:%0d exp=23:59:59", hour, min, sec);
        end
        for (int i = 0; i < 4; i++) step();
        total++;
        if ({hour, min, sec, tick} !== {7'd0, 7'd0, 7'd0, 1'b1}) begin
            bad++; $display("FAIL roll_wrap got=%0d:%0d:%0d t=%b exp=0:0:0 t=1", hour, min, sec, tick);
        end
    endtask

    task automatic test_set_edit();
        int seq [12] = '{4, 1, 1, 1, 0, 0, 0, 0, 2, 1, 5, 4};
        do_reset();
        for (int k = 0; k < 11; k++) begin
            pulse(seq[k]);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++; $display("FAIL edit k=%0d got=%h exp=%h", k, obs_vec(), exp_vec());
            end
            if (k == 3 || k == 7 || k == 9) begin
                total++;
                if (hour !== ((k == 3) ? 7'd3 : 7'd23) || min !== ((k == 9) ? 7'd1 : 7'd0)) begin
                    bad++; $display("FAIL edit_val k=%0d got=%0d:%0d", k, hour, min);
                end
            end
        end
        // exit edge plus release edge done; two quiet edges then the tick
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (tick !== (i == 2) || norm !== 1'b1 || obs_vec() !== exp_vec()) begin
                bad++; $display("FAIL esc_tick i=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_mode_off();
        int h0;
        do_reset();
        mode = 1'b0;
        for (int k = 0; k < 6; k++) begin
            pulse(k);
            total++;
            if (obs_vec() !== exp_vec() || norm !== 1'b1 || sel !== 1'b0) begin
                bad++; $display("FAIL mode_off k=%0d got=%h exp=%h", k, obs_vec(), exp_vec());
            end
        end
        mode = 1'b1;
        pulse(4);
        h0 = m_hour();
        mode = 1'b0;
        up = 1'b1;
        step();
        mode = 1'b1;
        step();
        up = 1'b0;
        step();
        total++;
        if (hour !== 7'(h0) || norm !== 1'b0 || obs_vec() !== exp_vec()) begin
            bad++; $display("FAIL held_up got=%h exp_hour=%0d", obs_vec(), h0);
        end
    endtask

    task automatic test_priority();
        int h0;
        do_reset();
        pulse(4);
        h0 = m_hour();
        esc = 1'b1; up = 1'b1;
        step();
        release_buttons();
        total++;
        if (norm !== 1'b1 || hour !== 7'(h0) || obs_vec() !== exp_vec()) begin
            bad++; $display("FAIL esc_up got=%h exp=%h", obs_vec(), exp_vec());
        end
        step();
        pulse(4);
        up = 1'b1; down = 1'b1;
        step();
        release_buttons();
        total++;
        if (norm !== 1'b0 || hour !== 7'(h0) || obs_vec() !== exp_vec()) begin
            bad++; $display("FAIL up_down got=%h exp=%h", obs_vec(), exp_vec());
        end
        step();
        left = 1'b1; right = 1'b1;
        step();
        release_buttons();
        total++;
        if (sel !== 1'b1 || obs_vec() !== exp_vec()) begin
            bad++; $display("FAIL left_right got=%h exp=%h", obs_vec(), exp_vec());
        end
        step();
    endtask

    task automatic test_reset_mid_set();
        do_reset();
        pulse(4);
        for (int k = 0; k < 5; k++) pulse(1);
        total++;
        if (hour !== 7'd5 || norm !== 1'b0) begin
            bad++; $display("FAIL pre_rst got hour=%0d norm=%b exp 5/0", hour, norm);
        end
        rst_n = 1'b0;
        model_reset();
        #1;
        total++;
        if (obs_vec() !== 24'h000002) begin
            bad++; $display("FAIL async_rst got=%h exp=%h", obs_vec(), 24'h000002);
        end
        enter = 1'b1;
        #1;
        rst_n = 1'b1;
        step();
        total++;
        if (norm !== 1'b0 || obs_vec() !== exp_vec()) begin
            bad++; $display("FAIL enter_held got=%h exp=%h", obs_vec(), exp_vec());
        end
        release_buttons();
        step();
    endtask

    task automatic test_random();
        bit [5:0] b;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            mode = ($urandom_range(0, 7) != 0);
            b = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'b000000;
            {esc, enter, left, right, up, down} = b;
            step();
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++; $display("FAIL random i=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
            end
        end
        release_buttons();
    endtask

    initial begin
        rst_n = 1'b0;
        mode  = 1'b0;
        release_buttons();
        model_reset();
        @(posedge clk); #1;
        test_reset();
        test_count();
        test_rollover();
        test_set_edit();
        test_mode_off();
        test_priority();
        test_reset_mid_set();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
